// File: rtl/core_pkg.sv
// Shared fetch-stage definitions: the NOP used to fill an empty IF/ID slot,
// the instruction size in bytes and the fetch-control state encoding.
package core_pkg;

    localparam logic [31:0] NOP_INS   = 32'h0000_0013;
    localparam int          INS_BYTES = 4;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO used twice by the fetch stage: once for the PCs of
// requests still waiting on memory, once for returned {pc, ins} pairs.
// Push and pop in the same cycle leave the count unchanged; flush wins over both.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int Depth = 2,
    parameter int Width = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [Width-1:0]         din,
    output logic [Width-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PtrW+1)'(Depth));
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy update; depth is a power of two so pointers wrap naturally
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            cnt_d = cnt_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
        end
    end

    // Control registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents are only meaningful under the valid count
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage. Owns the fetch PC, issues word requests under a
// credit limit so returned instructions always fit the output queue, pairs
// each response with its request PC and presents {ins, pc} to IF/ID.
// A redirect flushes the queue; requests already in flight are counted in
// drop_cnt and their responses discarded while in FLUSH.
module ifetch
    import core_pkg::*;
#(
    parameter int                  WordSize    = 32,
    parameter logic [WordSize-1:0] ResetVector = '0,
    parameter int                  QueueDepth  = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WordSize-1:0] imem_addr,
    input  logic                imem_resp_valid,
    input  logic [31:0]         imem_resp_data,
    input  logic                stall,
    input  logic                redirect,
    input  logic [WordSize-1:0] redirect_pc,
    output logic [31:0]         ins,
    output logic [WordSize-1:0] pc,
    output logic                ins_valid
);

    localparam int CntW = $clog2(QueueDepth) + 1;
    localparam int EntW = WordSize + 32;

    fetch_state_t        state_q, state_d;
    logic [WordSize-1:0] fetch_pc_q, fetch_pc_d;
    logic [WordSize-1:0] last_pc_q, last_pc_d;
    logic [CntW-1:0]     outstanding_q, outstanding_d;
    logic [CntW-1:0]     drop_cnt_q, drop_cnt_d;

    logic [EntW-1:0]     q_dout;
    logic                q_full, q_empty;
    logic [CntW-1:0]     q_count;
    logic [WordSize-1:0] pend_dout;
    logic                pend_full, pend_empty;
    logic [CntW-1:0]     pend_count;

    logic                pop, accept;
    logic                resp_any, resp_drop, resp_live;
    logic [CntW:0]       credit_used;
    logic                unused_ok;

    assign unused_ok = ^{q_full, pend_empty, pend_count, redirect_pc[1:0]};

    // A response is only meaningful if something is in flight; during redirect
    // or while draining stale requests it is thrown away.
    assign pop         = ins_valid && !stall;
    assign accept      = imem_req_valid && imem_req_ready;
    assign resp_any    = imem_resp_valid && !rst && ((outstanding_q != '0) || (drop_cnt_q != '0));
    assign resp_drop   = resp_any && (redirect || (drop_cnt_q != '0));
    assign resp_live   = resp_any && !resp_drop;
    assign credit_used = {1'b0, outstanding_q} + {1'b0, q_count} - (CntW+1)'(pop);

    assign imem_addr = fetch_pc_q;
    assign ins_valid = !q_empty;
    assign ins       = q_empty ? NOP_INS   : q_dout[31:0];
    assign pc        = q_empty ? last_pc_q : q_dout[EntW-1:32];

    fetch_fifo #(.Depth(QueueDepth), .Width(WordSize)) u_pend (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (resp_live),
        .flush (redirect),
        .din   (fetch_pc_q),
        .dout  (pend_dout),
        .full  (pend_full),
        .empty (pend_empty),
        .count (pend_count)
    );

    fetch_fifo #(.Depth(QueueDepth), .Width(EntW)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_live),
        .pop   (pop),
        .flush (redirect),
        .din   ({pend_dout, imem_resp_data}),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // Fetch PC, in-flight bookkeeping and last presented PC
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        last_pc_d     = q_empty ? last_pc_q : q_dout[EntW-1:32];
        if (redirect) begin
            fetch_pc_d    = {redirect_pc[WordSize-1:2], 2'b00};
            outstanding_d = '0;
            drop_cnt_d    = drop_cnt_q + outstanding_q - CntW'(resp_any);
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + WordSize'(INS_BYTES);
            outstanding_d = outstanding_q + CntW'(accept) - CntW'(resp_live);
            drop_cnt_d    = drop_cnt_q - CntW'(resp_drop);
        end
    end

    // FSM next state: FLUSH while stale responses remain to be discarded
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (redirect && (drop_cnt_d != '0)) state_d = FLUSH;
            FLUSH:   if (drop_cnt_d == '0)               state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM output: issue only in RUN, never on redirect, and only with a free credit
    always_comb begin
        imem_req_valid = 1'b0;
        if (!rst && (state_q == RUN) && !redirect && !pend_full &&
            (credit_used < (CntW+1)'(QueueDepth))) begin
            imem_req_valid = 1'b1;
        end
    end

    // State register and fetch bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= ResetVector;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            last_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            last_pc_q     <= last_pc_d;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a main instance (ResetVector 0) driven by an in-order
// memory model of selectable latency, and a second instance (ResetVector
// 0xFFFFFFF8) on a 1-cycle memory whose ready toggles 1010... Every accepted
// request is checked against a model PC and queued as an expected {pc, ins};
// redirects clear the expectations, and each pop is compared in order.
module tb_ifetch;

    localparam int          QD      = 2;
    localparam logic [31:0] WRAP_RV = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, resp_valid, stall, redirect, ins_valid;
    logic [31:0] addr, resp_data, rdr_pc, ins, pc;

    logic        req_valid_w, req_ready_w, resp_valid_w, ins_valid_w, tie0;
    logic [31:0] addr_w, resp_data_w, ins_w, pc_w, tie_pc;

    ent_t        sb_q[$];
    ent_t        wq[$];
    mreq_t       memq[$];
    logic [31:0] wpcs[$];
    int          cyc, lat, n_pass, n_total;
    logic [31:0] mpc, mpc_w, addrw_cap, addrw_prev, hold_addr;
    logic        accw, accw_prev, hold_w, found;

    ifetch #(.WordSize(32), .ResetVector(32'h0), .QueueDepth(QD)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_addr(addr),
        .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
        .stall(stall), .redirect(redirect), .redirect_pc(rdr_pc),
        .ins(ins), .pc(pc), .ins_valid(ins_valid)
    );

    ifetch #(.WordSize(32), .ResetVector(WRAP_RV), .QueueDepth(QD)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid_w), .imem_req_ready(req_ready_w), .imem_addr(addr_w),
        .imem_resp_valid(resp_valid_w), .imem_resp_data(resp_data_w),
        .stall(tie0), .redirect(tie0), .redirect_pc(tie_pc),
        .ins(ins_w), .pc(pc_w), .ins_valid(ins_valid_w)
    );

    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_total++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    endtask

    // Drive memory responses for this cycle, then sample and score both instances.
    task automatic cyc_begin();
        ent_t e;
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = ins_of(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            resp_valid = 1'b0;
            resp_data  = $urandom;
        end
        resp_valid_w = accw_prev;
        resp_data_w  = ins_of(addrw_prev);
        req_ready_w  = (cyc % 2 == 0);
        #1;
        accw      = 1'b0;
        addrw_cap = addr_w;
        if (!rst) begin
            check("credit", (sb_q.size() <= QD), 1);
            if (ins_valid && !stall && !redirect) begin
                check("sb_avail", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_pc", pc, e.pc);
                    check("sb_ins", ins, e.ins);
                end
            end
            if (redirect) begin
                sb_q.delete();
                mpc = {rdr_pc[31:2], 2'b00};
            end
            if (req_valid && req_ready) begin
                check("req_addr", addr, mpc);
                sb_q.push_back('{pc: mpc, ins: ins_of(mpc)});
                memq.push_back('{due: cyc + lat, addr: addr});
                mpc += 32'd4;
            end
            if (hold_w) check("w_addr_hold", addr_w, hold_addr);
            hold_w    = req_valid_w && !req_ready_w;
            hold_addr = addr_w;
            check("w_credit", (wq.size() <= QD), 1);
            if (ins_valid_w) begin
                check("w_sb_avail", (wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    e = wq.pop_front();
                    check("w_sb_pc", pc_w, e.pc);
                    check("w_sb_ins", ins_w, e.ins);
                end
                wpcs.push_back(pc_w);
            end
            accw = req_valid_w && req_ready_w;
            if (accw) begin
                check("w_req_addr", addr_w, mpc_w);
                wq.push_back('{pc: mpc_w, ins: ins_of(mpc_w)});
                mpc_w += 32'd4;
            end
        end
    endtask

    task automatic cyc_end();
        @(posedge clk);
        cyc++;
        accw_prev  = accw;
        addrw_prev = addrw_cap;
        @(negedge clk);
    endtask

    task automatic step();
        cyc_begin();
        cyc_end();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        sb_q.delete(); memq.delete(); wq.delete(); wpcs.delete();
        mpc = 32'h0; mpc_w = WRAP_RV;
        accw_prev = 1'b0; hold_w = 1'b0;
        cyc_begin(); cyc_end();
        cyc_begin();
        check("rst_ins", ins, NOP);
        check("rst_pc", pc, 32'h0);
        check("rst_vld", ins_valid, 0);
        check("rst_req", req_valid, 0);
        check("rst_addr", addr, 32'h0);
        check("rst_w_addr", addr_w, WRAP_RV);
        check("rst_w_vld", ins_valid_w, 0);
        cyc_end();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; rdr_pc = '0;
        req_ready = 1'b1; resp_valid = 1'b0; resp_data = '0;
        req_ready_w = 1'b1; resp_valid_w = 1'b0; resp_data_w = '0;
        tie0 = 1'b0; tie_pc = '0;
        lat = 1; cyc = 0; n_pass = 0; n_total = 0;
        accw = 1'b0; accw_prev = 1'b0; addrw_prev = '0; addrw_cap = '0;
        hold_w = 1'b0; hold_addr = '0; mpc = '0; mpc_w = WRAP_RV; found = 1'b0;
        @(negedge clk);

        // Reset and first fetches with a 1-cycle memory
        do_reset();
        cyc_begin(); check("first_req", req_valid, 1); check("first_addr", addr, 32'h0); cyc_end();
        cyc_begin(); check("lat_vld0", ins_valid, 0); cyc_end();
        cyc_begin(); check("lat_vld1", ins_valid, 1); check("pc0", pc, 32'h0); cyc_end();
        cyc_begin(); check("pc4_vld", ins_valid, 1); check("pc4", pc, 32'h4); cyc_end();

        // Stall for three cycles with pc 0x8 at the head
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc_begin();
            check("stall_vld", ins_valid, 1);
            check("stall_pc", pc, 32'h8);
            check("stall_ins", ins, ins_of(32'h8));
            cyc_end();
        end
        stall = 1'b0;
        repeat (12) step();

        // Wrap instance: pc sequence across the top of the address space
        check("w_npops", (wpcs.size() >= 3), 1);
        if (wpcs.size() >= 3) begin
            check("w_pc0", wpcs[0], 32'hFFFF_FFF8);
            check("w_pc1", wpcs[1], 32'hFFFF_FFFC);
            check("w_pc2", wpcs[2], 32'h0000_0000);
        end

        // Redirect with two requests in flight on a 3-cycle memory
        lat = 3;
        do_reset();
        step(); step();
        redirect = 1'b1; rdr_pc = 32'h103;
        cyc_begin(); check("rdr_noreq", req_valid, 0); cyc_end();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc_begin();
            check("flush_noreq", req_valid, 0);
            check("flush_vld", ins_valid, 0);
            cyc_end();
        end
        cyc_begin(); check("rdr_req", req_valid, 1); check("rdr_addr", addr, 32'h100); cyc_end();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc_begin();
            if (ins_valid) begin
                found = 1'b1;
                check("rdr_first_pc", pc, 32'h100);
            end
            cyc_end();
        end
        check("rdr_first_seen", found, 1);
        repeat (6) step();

        // Redirect coinciding with a response and with stall
        lat = 1;
        do_reset();
        repeat (4) step();
        redirect = 1'b1; stall = 1'b1; rdr_pc = 32'h200;
        step();
        redirect = 1'b0; stall = 1'b0;
        cyc_begin(); check("rs_vld_r1", ins_valid, 0); check("rs_req", req_valid, 1); check("rs_addr", addr, 32'h200); cyc_end();
        cyc_begin(); check("rs_vld_r2", ins_valid, 0); cyc_end();
        cyc_begin(); check("rs_vld_r3", ins_valid, 1); check("rs_pc_r3", pc, 32'h200); cyc_end();
        repeat (6) step();

        // Fill the queue under stall, then reset mid-operation
        stall = 1'b1;
        repeat (4) step();
        check("full_vld", ins_valid, 1);
        check("full_noreq", req_valid, 0);
        do_reset();
        cyc_begin(); check("mr_req", req_valid, 1); check("mr_addr", addr, 32'h0); cyc_end();
        repeat (8) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
